// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy/owner-tag scoreboard,
// write-first bypass on reads and a reset-release readiness sequencer.
module regfile_mp #(
  parameter  int XLEN = 64,
  parameter  int NREG = 32,
  parameter  int NRD  = 4,
  parameter  int NWR  = 2,
  parameter  int TAGW = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_en_i   [NRD],
  input  logic [AW-1:0]   rd_addr_i [NRD],
  output logic [XLEN-1:0] rd_data_o [NRD],
  output logic            rd_busy_o [NRD],
  input  logic            al_en_i   [NWR],
  input  logic [AW-1:0]   al_addr_i [NWR],
  input  logic [TAGW-1:0] al_tag_i  [NWR],
  input  logic            wb_en_i   [NWR],
  input  logic [AW-1:0]   wb_addr_i [NWR],
  input  logic [TAGW-1:0] wb_tag_i  [NWR],
  input  logic [XLEN-1:0] wb_data_i [NWR],
  output logic            wb_ready_o
);

  typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_t;

  state_t          r_state;
  logic            r_ready;
  logic [XLEN-1:0] r_data [NREG];
  logic            r_busy [NREG];
  logic [TAGW-1:0] r_tag  [NREG];

  logic            w_wb_act [NWR];
  logic            w_al_act [NWR];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state <= ST_INIT;
          r_ready <= 1'b0;
        end
        ST_INIT: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
        ST_RUN: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_RST;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ready_o = r_ready;

  // Register 0 is hardwired: requests addressed to it never become active.
  for (genvar gi = 0; gi < NWR; gi++) begin : g_wr
    assign w_wb_act[gi] = r_ready && wb_en_i[gi] && (wb_addr_i[gi] != '0);
    assign w_al_act[gi] = r_ready && al_en_i[gi] && (al_addr_i[gi] != '0);
  end

  // Later loop iterations override earlier ones, so the youngest port wins
  // and an allocate overrides a same-cycle busy clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_data[r] <= '0;
        r_busy[r] <= 1'b0;
        r_tag[r]  <= '0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (w_wb_act[p]) begin
          r_data[wb_addr_i[p]] <= wb_data_i[p];
          if (wb_tag_i[p] == r_tag[wb_addr_i[p]])
            r_busy[wb_addr_i[p]] <= 1'b0;
        end
      end
      for (int p = 0; p < NWR; p++) begin
        if (w_al_act[p]) begin
          r_busy[al_addr_i[p]] <= 1'b1;
          r_tag[al_addr_i[p]]  <= al_tag_i[p];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    always_comb begin
      w_data = r_data[rd_addr_i[gi]];
      w_busy = r_busy[rd_addr_i[gi]];
      for (int p = 0; p < NWR; p++) begin
        if (w_wb_act[p] && (wb_addr_i[p] == rd_addr_i[gi])) begin
          w_data = wb_data_i[p];
          if (wb_tag_i[p] == r_tag[rd_addr_i[gi]])
            w_busy = 1'b0;
        end
      end
      if (!rd_en_i[gi] || (rd_addr_i[gi] == '0)) begin
        w_data = '0;
        w_busy = 1'b0;
      end
    end

    assign rd_data_o[gi] = w_data;
    assign rd_busy_o[gi] = w_busy;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (power of 2, AW = log2(NREG)).
REQ-003 SHALL have parameter NRD, default 4, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write-back and allocate ports; port index order = program order (higher index younger).
REQ-005 SHALL have parameter TAGW, default 4, in-flight producer tag width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports rd_en_i[NRD], rd_addr_i[NRD]  input  1/AW  read enable, read address.
REQ-009 SHALL have ports rd_data_o[NRD]  output  XLEN  read data; rd_busy_o[NRD]  output  1  operand still pending.
REQ-010 SHALL have ports al_en_i[NWR], al_addr_i[NWR], al_tag_i[NWR]  input  1/AW/TAGW  destination allocate at dispatch.
REQ-011 SHALL have ports wb_en_i[NWR], wb_addr_i[NWR], wb_tag_i[NWR], wb_data_i[NWR]  input  1/AW/TAGW/XLEN  write-back.
REQ-012 SHALL have port wb_ready_o  output  1  write-back accepted; low only during reset and the first cycle after reset release.

Function
REQ-013 SHALL hold NREG x XLEN storage plus per-register busy bit and TAGW owner tag.
REQ-014 Register 0 SHALL read 0, never busy; writes and allocates to address 0 SHALL be ignored.
REQ-015 Reads SHALL be combinational; rd_en_i low SHALL force rd_data_o = 0 and rd_busy_o = 0.
REQ-016 Write-back with wb_en_i and wb_ready_o high SHALL update storage at the next rising edge, regardless of tag.
REQ-017 Same-cycle write-back bypass: read of an address being written this cycle SHALL return wb_data_i (write-first); youngest matching port wins.
REQ-018 Two write-backs to the same address in one cycle SHALL commit the higher port index only.
REQ-019 Allocate SHALL set busy and record al_tag_i at the next edge; two allocates to the same address SHALL record the higher port index.
REQ-020 Write-back SHALL clear busy only when wb_tag_i equals stored owner tag (WAW-safe); mismatch SHALL update data, keep busy.
REQ-021 Allocate and matching write-back to the same address in one cycle SHALL leave busy set with the new tag (allocate wins).
REQ-022 rd_busy_o SHALL reflect registered busy, except it SHALL be 0 when a same-cycle write-back with matching owner tag targets that address.
REQ-023 Readiness FSM: states RST (reset asserted) -> INIT (one cycle after release) -> RUN; wb_ready_o = 1 only in RUN; write-backs and allocates outside RUN SHALL be ignored.
REQ-024 Read ports SHALL be fully independent; any number may address the same register.

Reset
REQ-025 Reset assertion SHALL immediately clear all storage to 0, all busy bits to 0, all tags to 0, and force wb_ready_o = 0.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight write-back or allocate of that cycle.
REQ-027 After reset, rd_data_o = 0 and rd_busy_o = 0 on every port.

Verification
REQ-028 Reset, release, wait 2 cycles; wb x5=0xA5 tag 0 -> next cycle read x5 = 0xA5, wb_ready_o high from 2nd cycle after release.
REQ-029 Same cycle wb port0 x7=1, port1 x7=2 -> read x7 = 2 during cycle (bypass) and afterwards.
REQ-030 Alloc x3 tag 1, then alloc x3 tag 2, then wb x3 tag 1 data 0x11 -> data 0x11, rd_busy high; wb x3 tag 2 data 0x22 -> busy clears, read 0x22.
REQ-031 Write x0 = 0xFFFF and allocate x0 -> read x0 = 0, rd_busy_o = 0.
REQ-032 Alloc x9 and matching wb x9 same cycle -> busy stays set with new tag.
REQ-033 Assert reset with busy x4 and pending wb -> all reads 0, busy 0, wb_ready_o 0 immediately.
